// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - byte FIFO plus start/handshake sequencer in front of UART_TX
//
// Purpose: queues bytes written from the bus and hands them to UART_TX one at a
// time, pulsing tx_en and following tx_state until the frame completes, then
// idling GAP_CYCLES before the next byte.
//
// Ports:
//   clk, RSTn          clock, synchronous active-low reset
//   wr_en, wr_data     push strobe and byte
//   enable             allow new bytes to be started
//   flush              discard everything queued (in-flight byte unaffected)
//   clr_err            clear sticky ovf / tout
//   tx_state           UART_TX busy indication
//   tx_en, tx_data     start pulse and byte to UART_TX
//   full, empty, level FIFO status (registered)
//   busy               sequencer not idle
//   ovf, tout          sticky overflow / start-timeout flags
//   irq_low            low-watermark interrupt
//
// Build option: define UART_TXQ_IRQ_EN to implement irq_low; otherwise it is
// tied low and LOW_WM has no effect.

module uart_tx_scheduler #(
  parameter int DEPTH_LOG2 = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 64,
  parameter int LOW_WM     = 2
) (
  input  logic                  clk,
  input  logic                  RSTn,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  clr_err,
  input  logic                  tx_state,
  output logic                  tx_en,
  output logic [7:0]            tx_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  busy,
  output logic                  ovf,
  output logic                  tout,
  output logic                  irq_low
);

  localparam int AW = DEPTH_LOG2;
  localparam logic [AW:0] DEPTH     = (AW+1)'(2**AW);
  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
  localparam logic [15:0] TOUT_LAST = 16'(TIMEOUT - 1);
  // Only meaningful when GAP_CYCLES > 0; GAP is never entered otherwise.
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_KICK, S_WAIT_BUSY, S_WAIT_DONE, S_GAP
  } state_t;

  state_t       state, state_n;
  logic [15:0]  cnt, cnt_n;
  logic [7:0]   mem [0:(1<<AW)-1];
  logic [AW:0]  wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, level_n;
  logic         push, pop, tout_set;

  // full is registered, so a push in the same cycle as a pop from a full FIFO
  // is still dropped. flush wins over any push.
  assign push = wr_en && !full && !flush;
  assign busy = (state != S_IDLE);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    pop      = 1'b0;
    tout_set = 1'b0;
    tx_en    = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable && !empty && !flush) begin
          pop     = 1'b1;
          state_n = S_KICK;
        end
      end
      S_KICK: begin
        tx_en   = 1'b1;
        cnt_n   = '0;
        state_n = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_state) begin
          state_n = S_WAIT_DONE;
        end else if (cnt == TOUT_LAST) begin
          tout_set = 1'b1;
          cnt_n    = '0;
          state_n  = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_state) begin
          cnt_n   = '0;
          state_n = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) state_n = S_IDLE;
        else                 cnt_n   = cnt + 16'd1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    if (flush) begin
      rd_ptr_n = wr_ptr;
    end else begin
      if (push) wr_ptr_n = wr_ptr + PTR_ONE;
      if (pop)  rd_ptr_n = rd_ptr + PTR_ONE;
    end
    level_n = wr_ptr_n - rd_ptr_n;
  end

  // Storage needs no reset: a slot is only read after its push advanced wr_ptr.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!RSTn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      tx_data <= 8'h00;
      ovf     <= 1'b0;
      tout    <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      level  <= level_n;
      full   <= (level_n == DEPTH);
      empty  <= (level_n == '0);
      if (pop) tx_data <= mem[rd_ptr[AW-1:0]];
      // A set event in the same cycle as clr_err takes priority.
      if (wr_en && full) ovf <= 1'b1;
      else if (clr_err)  ovf <= 1'b0;
      if (tout_set)      tout <= 1'b1;
      else if (clr_err)  tout <= 1'b0;
    end
  end

`ifdef UART_TXQ_IRQ_EN
  localparam logic [AW:0] LOW_WM_L = (AW+1)'(LOW_WM);
  logic armed;

  // armed remembers that the queue was above the watermark, so the interrupt
  // fires on the falling crossing rather than whenever the queue is short.
  always_ff @(posedge clk) begin
    if (!RSTn) begin
      irq_low <= 1'b0;
      armed   <= 1'b0;
    end else if (flush) begin
      irq_low <= 1'b0;
      armed   <= 1'b0;
    end else if (level > LOW_WM_L) begin
      irq_low <= 1'b0;
      armed   <= 1'b1;
    end else if (armed && enable) begin
      irq_low <= 1'b1;
      armed   <= 1'b0;
    end
  end
`else
  localparam int unused_low_wm = LOW_WM;
  assign irq_low = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - directed self-checking bench for uart_tx_scheduler

module tb_uart_tx_scheduler;

  logic       clk = 1'b0;
  logic       RSTn;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       enable;
  logic       flush;
  logic       clr_err;
  logic       tx_state;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       busy;
  logic       ovf;
  logic       tout;
  logic       irq_low;

  int errors = 0;
  int checks = 0;

  uart_tx_scheduler dut (
    .clk(clk), .RSTn(RSTn), .wr_en(wr_en), .wr_data(wr_data), .enable(enable),
    .flush(flush), .clr_err(clr_err), .tx_state(tx_state), .tx_en(tx_en),
    .tx_data(tx_data), .full(full), .empty(empty), .level(level), .busy(busy),
    .ovf(ovf), .tout(tout), .irq_low(irq_low)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    wr_data = b;
    wr_en   = 1'b1;
    step(1);
    wr_en   = 1'b0;
  endtask

  // Waits (bounded) for a start pulse, checks the byte, then plays a short frame.
  task automatic send_frame(input logic [7:0] exp, input string tag);
    int n;
    n = 0;
    while (tx_en !== 1'b1 && n < 60) begin
      step(1);
      n++;
    end
    chk({tag, "_tx_en"}, tx_en, 1);
    chk({tag, "_data"}, tx_data, exp);
    step(1);
    tx_state = 1'b1;
    step(2);
    tx_state = 1'b0;
  endtask

  initial begin
    int kicks;
    logic exp_irq;
    RSTn = 1'b0; wr_en = 1'b1; wr_data = 8'h55; enable = 1'b0;
    flush = 1'b0; clr_err = 1'b0; tx_state = 1'b0;

    // 1: reset with wr_en held high
    step(2);
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_ovf", ovf, 0);
    chk("rst_tout", tout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_irq", irq_low, 0);
    wr_en = 1'b0; RSTn = 1'b1; enable = 1'b1;
    step(1);

    // 2: single byte latency and gap
    push(8'hA5);
    chk("t2_level_after_push", level, 1);
    chk("t2_no_early_kick", tx_en, 0);
    step(1);
    chk("t2_tx_en", tx_en, 1);
    chk("t2_tx_data", tx_data, 8'hA5);
    chk("t2_busy", busy, 1);
    chk("t2_level_after_pop", level, 0);
    step(1);
    chk("t2_tx_en_one_cycle", tx_en, 0);
    step(2);
    tx_state = 1'b1;
    step(10);
    tx_state = 1'b0;
    step(2);
    chk("t2_busy_in_gap", busy, 1);
    step(1);
    chk("t2_busy_dropped", busy, 0);
    chk("t2_tx_data_held", tx_data, 8'hA5);

    // 3: overflow then drain in order
    enable = 1'b0;
    for (int i = 0; i < 17; i++) begin
      push(8'(i));
      if (i == 15) begin
        chk("t3_full_at_16", full, 1);
        chk("t3_no_ovf_yet", ovf, 0);
      end
    end
    chk("t3_level", level, 16);
    chk("t3_full", full, 1);
    chk("t3_ovf", ovf, 1);
    enable = 1'b1;
    for (int i = 0; i < 16; i++) send_frame(8'(i), "t3_byte");
    kicks = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (tx_en === 1'b1) kicks++;
    end
    chk("t3_no_extra_kick", kicks, 0);
    chk("t3_empty", empty, 1);
    chk("t3_ovf_sticky", ovf, 1);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    chk("t3_ovf_cleared", ovf, 0);

    // 4: start timeout
    push(8'h3C);
    step(1);
    chk("t4_tx_en", tx_en, 1);
    chk("t4_tx_data", tx_data, 8'h3C);
    step(64);
    chk("t4_tout_not_yet", tout, 0);
    chk("t4_busy_waiting", busy, 1);
    step(1);
    chk("t4_tout_set", tout, 1);
    step(2);
    chk("t4_idle", busy, 0);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    chk("t4_tout_cleared", tout, 0);

    // 5: flush while the first byte is in WAIT_DONE
    enable = 1'b0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    chk("t5_level4", level, 4);
    enable = 1'b1;
    step(1);
    chk("t5_tx_en", tx_en, 1);
    chk("t5_tx_data", tx_data, 8'h11);
    step(1);
    tx_state = 1'b1;
    step(1);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("t5_level0", level, 0);
    chk("t5_empty", empty, 1);
    chk("t5_busy_inflight", busy, 1);
    step(2);
    tx_state = 1'b0;
    kicks = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (tx_en === 1'b1) kicks++;
    end
    chk("t5_no_kick", kicks, 0);
    chk("t5_idle", busy, 0);

    // 6: low watermark interrupt
    enable = 1'b0;
    for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
    step(1);
    chk("t6_irq_full_queue", irq_low, 0);
    enable = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(8'h50 + k - 1), "t6_byte");
      chk("t6_level", level, 5 - k);
`ifdef UART_TXQ_IRQ_EN
      exp_irq = ((5 - k) <= 2);
`else
      exp_irq = 1'b0;
`endif
      chk("t6_irq", irq_low, exp_irq);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
